// File: rtl/char_feature_extract_if.sv
// Feature record stream from char_feature_extract to the recognition stage.
// The producer drives the record fields and o_valid; the consumer drives i_ready.
interface char_feature_extract_if #(
    parameter int CNT_W = 4,
    parameter int FG_W  = 10
);
    logic             o_valid;
    logic             i_ready;
    logic [2:0]       o_slot;
    logic [CNT_W-1:0] o_h1;
    logic [CNT_W-1:0] o_h2;
    logic [FG_W-1:0]  o_fg;
    logic [CNT_W-1:0] o_v;

    modport master (output o_valid, o_slot, o_h1, o_h2, o_fg, o_v, input i_ready);
    modport slave  (input o_valid, o_slot, o_h1, o_h2, o_fg, o_v, output i_ready);
endinterface

// File: rtl/char_feature_extract.sv
// Per-slot character feature accumulation with a framed 7-record output stream.
// Optional centre-column vertical transition counter: define CHAR_FEAT_VCOL_EN.
//
//   state | meaning
//   IDLE  | no record pending; frame_start snapshots the accumulators
//   SEND  | presenting snapshot[ptr]; advances on i_ready
module char_feature_extract #(
    parameter int CNT_W = 4,
    parameter int FG_W  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_bin,
    input  logic [11:0] edge_left,
    input  logic [11:0] edge_right,
    input  logic [11:0] char_up_position,
    input  logic [11:0] char_down_position,
    input  logic [11:0] row_scanf_line1,
    input  logic [11:0] row_scanf_line2,
    input  logic [11:0] Partition_line1,
    input  logic [11:0] Partition_line2,
    input  logic [11:0] Partition_line3,
    input  logic [11:0] Partition_line4,
    input  logic [11:0] Partition_line5,
    input  logic [11:0] Partition_line6,
    output logic        o_done,
    output logic        o_overrun,
    char_feature_extract_if.master rec
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FG_W-1:0]  FG_MAX  = '1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [11:0] bnd [0:7];
    always_comb begin
        bnd[0] = edge_left;
        bnd[1] = Partition_line1;
        bnd[2] = Partition_line2;
        bnd[3] = Partition_line3;
        bnd[4] = Partition_line4;
        bnd[5] = Partition_line5;
        bnd[6] = Partition_line6;
        bnd[7] = edge_right;
    end

    // Descending scan so the lowest matching slot is the one left standing.
    logic       hit;
    logic [2:0] slot;
    always_comb begin
        hit  = 1'b0;
        slot = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (bnd[k] <= i_x && i_x < bnd[k+1]) begin
                hit  = 1'b1;
                slot = 3'(k);
            end
        end
        hit = hit & i_de;
    end

    logic prev;
    logic entering;
    logic in_band;
    logic inc_h1;
    logic inc_h2;
    logic inc_fg;
    assign entering = (i_x == bnd[slot]);
    assign in_band  = (i_y >= char_up_position) && (i_y <= char_down_position);
    assign inc_h1   = hit && (i_y == row_scanf_line1) && !(prev && !entering) && i_bin;
    assign inc_h2   = hit && (i_y == row_scanf_line2) && !(prev && !entering) && i_bin;
    assign inc_fg   = hit && in_band && i_bin;

    logic [CNT_W-1:0] h1_acc [0:6];
    logic [CNT_W-1:0] h2_acc [0:6];
    logic [FG_W-1:0]  fg_acc [0:6];
    logic [CNT_W-1:0] h1_nxt [0:6];
    logic [CNT_W-1:0] h2_nxt [0:6];
    logic [FG_W-1:0]  fg_nxt [0:6];
    logic [CNT_W-1:0] h1_snap [0:6];
    logic [CNT_W-1:0] h2_snap [0:6];
    logic [FG_W-1:0]  fg_snap [0:6];

    // A pixel arriving with frame_start counts into the freshly cleared frame.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            h1_nxt[k] = frame_start ? '0 : h1_acc[k];
            h2_nxt[k] = frame_start ? '0 : h2_acc[k];
            fg_nxt[k] = frame_start ? '0 : fg_acc[k];
            if (inc_h1 && slot == 3'(k) && h1_nxt[k] != CNT_MAX)
                h1_nxt[k] = h1_nxt[k] + CNT_W'(1);
            if (inc_h2 && slot == 3'(k) && h2_nxt[k] != CNT_MAX)
                h2_nxt[k] = h2_nxt[k] + CNT_W'(1);
            if (inc_fg && slot == 3'(k) && fg_nxt[k] != FG_MAX)
                fg_nxt[k] = fg_nxt[k] + FG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            for (int k = 0; k < 7; k++) begin
                h1_acc[k] <= '0;
                h2_acc[k] <= '0;
                fg_acc[k] <= '0;
            end
        end else begin
            if (hit)
                prev <= i_bin;
            for (int k = 0; k < 7; k++) begin
                h1_acc[k] <= h1_nxt[k];
                h2_acc[k] <= h2_nxt[k];
                fg_acc[k] <= fg_nxt[k];
            end
        end
    end

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] ptr_inc;
    logic       load_first;
    logic       accept;
    logic       last_acc;
    assign ptr_inc    = ptr + 3'd1;
    assign load_first = (state == IDLE) && frame_start;
    assign accept     = (state == SEND) && rec.i_ready;
    assign last_acc   = accept && (ptr == 3'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            o_done      <= 1'b0;
            o_overrun   <= 1'b0;
            rec.o_valid <= 1'b0;
            rec.o_slot  <= 3'd0;
            rec.o_h1    <= '0;
            rec.o_h2    <= '0;
            rec.o_fg    <= '0;
            for (int k = 0; k < 7; k++) begin
                h1_snap[k] <= '0;
                h2_snap[k] <= '0;
                fg_snap[k] <= '0;
            end
        end else begin
            o_done <= last_acc;
            if (state == SEND && frame_start)
                o_overrun <= 1'b1;
            if (load_first) begin
                for (int k = 0; k < 7; k++) begin
                    h1_snap[k] <= h1_acc[k];
                    h2_snap[k] <= h2_acc[k];
                    fg_snap[k] <= fg_acc[k];
                end
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= SEND;
                        ptr         <= 3'd0;
                        rec.o_valid <= 1'b1;
                        rec.o_slot  <= 3'd0;
                        rec.o_h1    <= h1_acc[0];
                        rec.o_h2    <= h2_acc[0];
                        rec.o_fg    <= fg_acc[0];
                    end
                end
                SEND: begin
                    if (rec.i_ready) begin
                        if (ptr == 3'd6) begin
                            state       <= IDLE;
                            ptr         <= 3'd0;
                            rec.o_valid <= 1'b0;
                            rec.o_slot  <= 3'd0;
                            rec.o_h1    <= '0;
                            rec.o_h2    <= '0;
                            rec.o_fg    <= '0;
                        end else begin
                            ptr        <= ptr_inc;
                            rec.o_slot <= ptr_inc;
                            rec.o_h1   <= h1_snap[ptr_inc];
                            rec.o_h2   <= h2_snap[ptr_inc];
                            rec.o_fg   <= fg_snap[ptr_inc];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHAR_FEAT_VCOL_EN
    logic [CNT_W-1:0] v_acc  [0:6];
    logic [CNT_W-1:0] v_nxt  [0:6];
    logic [CNT_W-1:0] v_snap [0:6];
    logic [CNT_W-1:0] v_out;
    logic [6:0]       last_line;
    logic [6:0]       last_nxt;
    logic [12:0]      csum;
    logic             at_ctr;

    // 13-bit sum keeps the carry so the centre of wide slots is exact.
    assign csum   = {1'b0, bnd[slot]} + {1'b0, bnd[slot + 3'd1]};
    assign at_ctr = hit && ({1'b0, i_x} == (csum >> 1)) && in_band;

    always_comb begin
        for (int k = 0; k < 7; k++) begin
            v_nxt[k]    = frame_start ? '0 : v_acc[k];
            last_nxt[k] = frame_start ? 1'b0 : last_line[k];
            if (at_ctr && slot == 3'(k)) begin
                if (i_y > char_up_position && !last_nxt[k] && i_bin && v_nxt[k] != CNT_MAX)
                    v_nxt[k] = v_nxt[k] + CNT_W'(1);
                last_nxt[k] = i_bin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_line <= '0;
            v_out     <= '0;
            for (int k = 0; k < 7; k++) begin
                v_acc[k]  <= '0;
                v_snap[k] <= '0;
            end
        end else begin
            last_line <= last_nxt;
            for (int k = 0; k < 7; k++) begin
                v_acc[k] <= v_nxt[k];
                if (load_first)
                    v_snap[k] <= v_acc[k];
            end
            if (load_first)
                v_out <= v_acc[0];
            else if (accept)
                v_out <= (ptr == 3'd6) ? '0 : v_snap[ptr_inc];
        end
    end

    assign rec.o_v = v_out;
`else
    assign rec.o_v = '0;
`endif
endmodule

// File: tb/tb_char_feature_extract.sv
// Self-checking bench for char_feature_extract: table vectors, directed corner
// sequences and random frames checked against a per-pixel feature model.
module tb_char_feature_extract;
    localparam int CNT_W = 4;
    localparam int FG_W  = 10;
    localparam int CMAX  = 15;
    localparam int FMAX  = 1023;
`ifdef CHAR_FEAT_VCOL_EN
    localparam bit VCOL = 1'b1;
`else
    localparam bit VCOL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        i_de = 1'b0;
    logic [11:0] i_x = '0;
    logic [11:0] i_y = '0;
    logic        i_bin = 1'b0;
    logic [11:0] edge_left = 12'd0;
    logic [11:0] edge_right = 12'd700;
    logic [11:0] char_up_position = 12'd10;
    logic [11:0] char_down_position = 12'd20;
    logic [11:0] row_scanf_line1 = 12'd5;
    logic [11:0] row_scanf_line2 = 12'd15;
    logic [11:0] Partition_line1 = 12'd100;
    logic [11:0] Partition_line2 = 12'd200;
    logic [11:0] Partition_line3 = 12'd300;
    logic [11:0] Partition_line4 = 12'd400;
    logic [11:0] Partition_line5 = 12'd500;
    logic [11:0] Partition_line6 = 12'd600;
    logic        o_done;
    logic        o_overrun;

    always #5 clk = ~clk;

    char_feature_extract_if #(.CNT_W(CNT_W), .FG_W(FG_W)) rec ();

    char_feature_extract #(.CNT_W(CNT_W), .FG_W(FG_W)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .i_de(i_de), .i_x(i_x), .i_y(i_y), .i_bin(i_bin),
        .edge_left(edge_left), .edge_right(edge_right),
        .char_up_position(char_up_position), .char_down_position(char_down_position),
        .row_scanf_line1(row_scanf_line1), .row_scanf_line2(row_scanf_line2),
        .Partition_line1(Partition_line1), .Partition_line2(Partition_line2),
        .Partition_line3(Partition_line3), .Partition_line4(Partition_line4),
        .Partition_line5(Partition_line5), .Partition_line6(Partition_line6),
        .o_done(o_done), .o_overrun(o_overrun), .rec(rec)
    );

    int n_chk = 0;
    int n_fail = 0;

    int m_h1 [7];
    int m_h2 [7];
    int m_fg [7];
    int m_v  [7];
    bit m_last [7];
    bit m_prev;
    int e_h1 [7];
    int e_h2 [7];
    int e_fg [7];
    int e_v  [7];
    int r_h1 [7];
    int r_h2 [7];
    int r_fg [7];
    int r_v  [7];
    int rec_idx;
    bit ovr_exp;

    typedef struct {
        int x;
        int y;
        bit de;
        bit bin;
        int p3;
        int exp_slot;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int bnd(input int k);
        case (k)
            0: return int'(edge_left);
            1: return int'(Partition_line1);
            2: return int'(Partition_line2);
            3: return int'(Partition_line3);
            4: return int'(Partition_line4);
            5: return int'(Partition_line5);
            6: return int'(Partition_line6);
            default: return int'(edge_right);
        endcase
    endfunction

    task automatic model_clear();
        for (int j = 0; j < 7; j++) begin
            m_h1[j] = 0; m_h2[j] = 0; m_fg[j] = 0; m_v[j] = 0; m_last[j] = 0;
        end
    endtask

    // Features of one pixel, straight from the slot/row/band rules.
    task automatic model_pix(input bit fs, input bit de, input int x, input int y, input bit bin);
        int k;
        int c;
        bit pe;
        if (fs) model_clear();
        if (!de) return;
        k = -1;
        for (int j = 0; j < 7; j++)
            if (k < 0 && bnd(j) <= x && x < bnd(j + 1)) k = j;
        if (k < 0) return;
        pe = (x == bnd(k)) ? 1'b0 : m_prev;
        if (y == int'(row_scanf_line1) && !pe && bin && m_h1[k] < CMAX) m_h1[k]++;
        if (y == int'(row_scanf_line2) && !pe && bin && m_h2[k] < CMAX) m_h2[k]++;
        if (y >= int'(char_up_position) && y <= int'(char_down_position) && bin && m_fg[k] < FMAX)
            m_fg[k]++;
        if (VCOL) begin
            c = (bnd(k) + bnd(k + 1)) / 2;
            if (x == c && y >= int'(char_up_position) && y <= int'(char_down_position)) begin
                if (y > int'(char_up_position) && !m_last[k] && bin && m_v[k] < CMAX) m_v[k]++;
                m_last[k] = bin;
            end
        end
        m_prev = bin;
    endtask

    task automatic cyc(input bit fs, input bit de, input int x, input int y, input bit bin);
        frame_start = fs;
        i_de  = de;
        i_x   = 12'(x);
        i_y   = 12'(y);
        i_bin = bin;
        model_pix(fs, de, x, y, bin);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        i_de = 1'b0;
    endtask

    task automatic rand_cyc();
        cyc(1'b0, $urandom_range(0, 4) != 0, $urandom_range(0, 749), $urandom_range(0, 24),
            1'($urandom_range(0, 1)));
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic collect(input int mode, input bit rnd, input int upto);
        int budget = 0;
        int pat = 0;
        bit rdy;
        bit stalled = 1'b0;
        int hs, hh1, hfg;
        while (rec_idx < upto && budget < 200) begin
            rdy = (mode == 0) ? 1'b1 :
                  (mode == 1) ? ((pat % 4 == 0) || (pat % 4 == 3)) : 1'($urandom_range(0, 1));
            pat++;
            chk("valid_in_send", int'(rec.o_valid), 1);
            if (stalled) begin
                chk("stall_slot", int'(rec.o_slot), hs);
                chk("stall_h1", int'(rec.o_h1), hh1);
                chk("stall_fg", int'(rec.o_fg), hfg);
            end
            rec.i_ready = rdy;
            if (rdy) begin
                chk("rec_slot", int'(rec.o_slot), rec_idx);
                chk("rec_h1", int'(rec.o_h1), e_h1[rec_idx]);
                chk("rec_h2", int'(rec.o_h2), e_h2[rec_idx]);
                chk("rec_fg", int'(rec.o_fg), e_fg[rec_idx]);
                chk("rec_v", int'(rec.o_v), e_v[rec_idx]);
                r_h1[rec_idx] = int'(rec.o_h1);
                r_h2[rec_idx] = int'(rec.o_h2);
                r_fg[rec_idx] = int'(rec.o_fg);
                r_v[rec_idx]  = int'(rec.o_v);
                rec_idx++;
                stalled = 1'b0;
            end else begin
                hs = int'(rec.o_slot); hh1 = int'(rec.o_h1); hfg = int'(rec.o_fg);
                stalled = 1'b1;
            end
            if (rnd) rand_cyc();
            else cyc(1'b0, 1'b0, 0, 0, 1'b0);
            budget++;
        end
        rec.i_ready = 1'b0;
        if (rec_idx < upto) chk("collect_timeout", rec_idx, upto);
    endtask

    task automatic snap_expect();
        for (int j = 0; j < 7; j++) begin
            e_h1[j] = m_h1[j]; e_h2[j] = m_h2[j]; e_fg[j] = m_fg[j]; e_v[j] = m_v[j];
        end
    endtask

    task automatic finish_checks();
        chk("done_pulse", int'(o_done), 1);
        chk("valid_after_last", int'(rec.o_valid), 0);
        chk("overrun_flag", int'(o_overrun), int'(ovr_exp));
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        chk("done_once", int'(o_done), 0);
    endtask

    task automatic run_frame(input int mode, input bit rnd);
        snap_expect();
        if (rnd)
            cyc(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 749), $urandom_range(0, 24),
                1'($urandom_range(0, 1)));
        else
            cyc(1'b1, 1'b0, 0, 0, 1'b0);
        rec_idx = 0;
        collect(mode, rnd, 7);
        finish_checks();
    endtask

    initial begin
        tbl[0]  = '{0,   12, 1'b1, 1'b1, 300, 0};
        tbl[1]  = '{99,  12, 1'b1, 1'b1, 300, 0};
        tbl[2]  = '{100, 12, 1'b1, 1'b1, 300, 1};
        tbl[3]  = '{599, 12, 1'b1, 1'b1, 300, 5};
        tbl[4]  = '{600, 12, 1'b1, 1'b1, 300, 6};
        tbl[5]  = '{699, 12, 1'b1, 1'b1, 300, 6};
        tbl[6]  = '{700, 12, 1'b1, 1'b1, 300, -1};
        tbl[7]  = '{350, 12, 1'b0, 1'b1, 300, -1};
        tbl[8]  = '{350, 12, 1'b1, 1'b0, 300, -1};
        tbl[9]  = '{350, 9,  1'b1, 1'b1, 300, -1};
        tbl[10] = '{350, 10, 1'b1, 1'b1, 300, 3};
        tbl[11] = '{350, 20, 1'b1, 1'b1, 300, 3};
        tbl[12] = '{350, 21, 1'b1, 1'b1, 300, -1};
        tbl[13] = '{250, 12, 1'b1, 1'b1, 50,  3};
        tbl[14] = '{60,  12, 1'b1, 1'b1, 50,  0};
        tbl[15] = '{199, 12, 1'b1, 1'b1, 50,  1};

        rec.i_ready = 1'b0;
        model_clear();
        m_prev  = 1'b0;
        ovr_exp = 1'b0;

        // reset state
        rst = 1'b1;
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        chk("rst_valid", int'(rec.o_valid), 0);
        chk("rst_slot", int'(rec.o_slot), 0);
        chk("rst_fg", int'(rec.o_fg), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_overrun", int'(o_overrun), 0);

        // empty frame still yields 7 zero records
        run_frame(0, 1'b0);

        // slot decode / band table
        foreach (tbl[i]) begin
            Partition_line3 = 12'(tbl[i].p3);
            cyc(1'b0, tbl[i].de, tbl[i].x, tbl[i].y, tbl[i].bin);
            Partition_line3 = 12'd300;
            run_frame(0, 1'b0);
            for (int k = 0; k < 7; k++)
                chk($sformatf("tbl%0d_fg%0d", i, k), r_fg[k], (k == tbl[i].exp_slot) ? 1 : 0);
        end

        // scan-line transitions, slot-entry clearing, saturation; stalled readout
        for (int x = 200; x < 300; x++)
            cyc(1'b0, 1'b1, x, 5, (x >= 210 && x < 220) || (x >= 230 && x < 240));
        for (int x = 190; x < 216; x++)
            cyc(1'b0, 1'b1, x, 15, 1'b1);
        for (int j = 0; j < 40; j++)
            cyc(1'b0, 1'b1, 500 + j, 5, 1'(j % 2));
        run_frame(1, 1'b0);
        for (int k = 0; k < 7; k++)
            chk($sformatf("h1_slot%0d", k), r_h1[k], (k == 2) ? 2 : (k == 5) ? CMAX : 0);
        chk("h2_slot1", r_h2[1], 1);
        chk("h2_slot2_entry", r_h2[2], 1);

        // foreground saturation
        for (int y = 10; y <= 20; y++)
            for (int x = 0; x < 100; x++)
                cyc(1'b0, 1'b1, x, y, 1'b1);
        run_frame(0, 1'b0);
        chk("fg_sat_slot0", r_fg[0], FMAX);
        chk("h2_slot0", r_h2[0], 1);

        // centre-column vertical bar 0,1,0,1 in slot 1
        for (int y = 10; y < 14; y++)
            cyc(1'b0, 1'b1, 150, y, 1'(y % 2));
        run_frame(0, 1'b0);
        chk("v_slot1", r_v[1], VCOL ? 2 : 0);
        chk("v_fg_slot1", r_fg[1], 2);

        // random frames with random ready and pixels during readout
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 300; i++) rand_cyc();
            run_frame(2, 1'b1);
        end

        // overrun: second frame_start while presenting slot 3
        for (int i = 0; i < 50; i++) rand_cyc();
        snap_expect();
        cyc(1'b1, 1'b0, 0, 0, 1'b0);
        rec_idx = 0;
        collect(0, 1'b1, 3);
        chk("ovr_slot_before", int'(rec.o_slot), 3);
        cyc(1'b1, 1'b0, 0, 0, 1'b0);
        ovr_exp = 1'b1;
        chk("ovr_set", int'(o_overrun), 1);
        chk("ovr_slot_held", int'(rec.o_slot), 3);
        collect(0, 1'b0, 7);
        finish_checks();
        run_frame(0, 1'b0);
        for (int k = 0; k < 7; k++)
            chk($sformatf("ovr_new_frame_fg%0d", k), r_fg[k] + r_h1[k] + r_h2[k], 0);

        // reset while presenting slot 4
        for (int i = 0; i < 50; i++) rand_cyc();
        snap_expect();
        cyc(1'b1, 1'b0, 0, 0, 1'b0);
        rec_idx = 0;
        collect(0, 1'b0, 4);
        chk("pre_rst_slot", int'(rec.o_slot), 4);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        model_clear();
        m_prev  = 1'b0;
        ovr_exp = 1'b0;
        chk("mid_rst_valid", int'(rec.o_valid), 0);
        chk("mid_rst_slot", int'(rec.o_slot), 0);
        chk("mid_rst_overrun", int'(o_overrun), 0);
        chk("mid_rst_done", int'(o_done), 0);
        chk("mid_rst_h1", int'(rec.o_h1), 0);
        chk("mid_rst_fg", int'(rec.o_fg), 0);
        run_frame(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/char_feature_extract.md
Name: char_feature_extract

Overview:
- Reads the character-division geometry (plate edges, six partition lines, character band, two row scan lines) and the binarized pixel stream.
- Accumulates per-character features for the 7 character slots of a plate, one frame at a time.
- At each frame start it snapshots the features and streams them out as 7 records over a valid/ready interface to the recognition/matching stage.

Parameters:
- CNT_W, 4, width of each transition counter (saturating)
- FG_W, 10, width of the per-slot foreground pixel counter (saturating)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse at start of each frame
- i_de  in  1  pixel valid
- i_x  in  12  pixel column
- i_y  in  12  pixel row
- i_bin  in  1  binarized pixel, 1 = character stroke
- edge_left, edge_right  in  12 each  plate horizontal bounds
- char_up_position, char_down_position  in  12 each  character band rows
- row_scanf_line1, row_scanf_line2  in  12 each  horizontal scan rows
- Partition_line1..Partition_line6  in  12 each  slot boundaries
- o_valid  out  1  record valid
- i_ready  in  1  downstream accepts record
- o_slot  out  3  slot index 0..6
- o_h1  out  CNT_W  0→1 transitions on row_scanf_line1 within slot
- o_h2  out  CNT_W  0→1 transitions on row_scanf_line2 within slot
- o_fg  out  FG_W  stroke pixels inside band within slot
- o_v  out  CNT_W  vertical centre-column transitions (0 when feature off)
- o_done  out  1  one-cycle pulse after slot 6 is accepted
- o_overrun  out  1  sticky: a snapshot was dropped

Behaviour:
- Slot decode (combinational):
  - Bounds B0 = edge_left, B1..B6 = Partition_line1..6, B7 = edge_right.
  - Slot k covers B[k] <= x < B[k+1]; the lowest matching k wins.
  - Pixels matching no slot, or with i_de = 0, are ignored. Boundaries are not required to be monotonic.
- Transition counting:
  - A per-row prev bit is cleared whenever x == B[k] for the decoded slot, i.e. on entering a slot.
  - h1[k] increments when i_y == row_scanf_line1 && prev == 0 && i_bin == 1; h2 is the same on row_scanf_line2.
  - Counters saturate at 2^CNT_W-1.
- Foreground: fg[k] increments when char_up_position <= i_y <= char_down_position && i_bin == 1; saturates at 2^FG_W-1.
- Geometry inputs are sampled live every cycle; no internal copy is kept.
- Frame handling, on frame_start:
  - Accumulators are cleared.
  - A pixel valid in the same cycle counts into the new frame, so accumulators load with that pixel's contribution.
  - If the state is IDLE, the pre-clear accumulator values are copied to the snapshot bank in the same edge.
- FSM:
  - IDLE: o_valid = 0. On frame_start: snapshot, slot pointer = 0, go to SEND.
  - SEND: o_valid = 1 with snapshot[pointer] on the outputs. Outputs are held stable while i_ready = 0.
  - On o_valid && i_ready: pointer increments. If pointer was 6, pulse o_done next cycle and return to IDLE.
  - frame_start while in SEND: the snapshot is not overwritten, o_overrun is set, and accumulators still clear.
- Latency: frame_start at edge N gives o_valid = 1 after edge N; with i_ready held at 1, all 7 records take 7 cycles.
- Frame with no valid pixels: 7 all-zero records are still emitted.
- Reset (rst = 1 at an edge), including mid-SEND:
  - State goes to IDLE; accumulators, snapshot, pointer, o_valid, o_done and o_overrun clear to 0.
  - All data outputs read 0.

Optional Feature:
- Macro: CHAR_FEAT_VCOL_EN.
- When defined:
  - Per slot, centre column c[k] = (B[k] + B[k+1]) >> 1, computed with a 13-bit sum.
  - A per-slot last-line bit stores i_bin at x == c[k] within the band.
  - v[k] increments (saturating) when the stored bit is 0 and the current bit is 1 at c[k], with i_y > char_up_position.
  - The last-line bit clears on frame_start.
- When undefined: no v logic is generated and o_v is tied to 0.

Test Plan:
- Plate 0..699, partitions 100,200,…,600; one row_scanf_line1 pattern with two stroke runs in slot 2 → after frame_start, record slot 2 has h1 = 2 and all other slots h1 = 0.
- Band rows 10..20, slot 0 fully stroke for 11 rows × 100 cols → slot 0 fg = 1023 (saturated).
- i_ready toggled 1,0,0,1 during SEND → records advance only on ready cycles, outputs are stable while stalled, and o_done pulses once after slot 6.
- Second frame_start during SEND at slot 3 → o_overrun = 1, slots 4..6 still carry the first snapshot, and the next frame's counts start from 0.
- rst asserted mid-SEND at slot 4 → o_valid = 0 next cycle, o_slot = 0, o_overrun = 0, and the next frame_start restarts at slot 0.
- With CHAR_FEAT_VCOL_EN: vertical bar pattern 0,1,0,1 on consecutive band rows at slot 1's centre column → o_v = 2 for slot 1; without the macro o_v = 0.
